// File: rtl/display_pkg.sv
// display_pkg -- shared constants and types for the 160x120 display path.
//   SCREEN_W/SCREEN_H : raster size.
//   *_COLOUR          : fill colours used by the draw engine.
//   S_*               : draw engine state encoding.
//   cmd_e             : command type latched with every accepted request.
//   draw_req_t        : latched geometry, colour and command.
package display_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] START_COLOUR    = 3'b010;
  localparam logic [2:0] GAMEOVER_COLOUR = 3'b100;
  localparam logic [2:0] BORDER_COLOUR   = 3'b111;
  localparam logic [2:0] BG_COLOUR       = 3'b000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  typedef enum logic [1:0] {
    CMD_DRAW  = 2'd0,
    CMD_ERASE = 2'd1,
    CMD_START = 2'd2,
    CMD_END   = 2'd3
  } cmd_e;

  // h is 7 bits wide so a full-screen fill (h=120) fits alongside block_h.
  typedef struct packed {
    cmd_e       cmd;
    logic [7:0] ox;
    logic [6:0] oy;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour;
  } draw_req_t;

  // Level of the request input that started command c.
  function automatic logic cmd_level(input cmd_e c, input logic draw, input logic erase,
                                     input logic draw_start, input logic draw_end);
    case (c)
      CMD_DRAW:  return draw;
      CMD_ERASE: return erase;
      CMD_START: return draw_start;
      default:   return draw_end;
    endcase
  endfunction

  function automatic logic is_screen(input cmd_e c);
    return (c == CMD_START) || (c == CMD_END);
  endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// xy_scan_counter -- row-major raster walker over a w x h window.
//   clk, resetn       : clock, async active-low reset.
//   load              : restart at (origin_x, origin_y).
//   step              : advance one pixel (x first, then y).
//   origin_x/y, w, h  : window; w,h must be non-zero while stepping.
//   x [8:0], y [7:0]  : current pixel, wide enough that origin+size never wraps.
//   last              : current pixel is the bottom-right one of the window.
module xy_scan_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] origin_x,
  input  logic [6:0] origin_y,
  input  logic [7:0] w,
  input  logic [6:0] h,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic       last
);

  logic [8:0] end_x;
  logic [7:0] end_y;

  assign end_x = {1'b0, origin_x} + {1'b0, w} - 9'd1;
  assign end_y = {1'b0, origin_y} + {1'b0, h} - 8'd1;
  assign last  = (x == end_x) && (y == end_y);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= {1'b0, origin_x};
      y <= {1'b0, origin_y};
    end else if (step) begin
      if (x == end_x) begin
        x <= {1'b0, origin_x};
        y <= y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

endmodule

// File: rtl/block_draw_engine.sv
// block_draw_engine -- paints a block, erases it, or fills the whole screen,
// one pixel per clock into a 160x120 framebuffer write port.
//   clk, resetn                      : clock, async active-low reset.
//   draw/erase/draw_start/draw_end   : level requests, priority
//                                      draw_start > draw_end > erase > draw.
//   block_x/y/w/h, block_colour      : block geometry and colour (latched on accept).
//   vga_x, vga_y, vga_colour, plot   : registered pixel write port.
//   done_draw, done_erase            : one-cycle completion pulses.
//   done_screen                      : high from completion until the request drops.
// Build option: define BLOCK_BORDER_EN to give drawn blocks a BORDER_COLOUR rim.
module block_draw_engine
  import display_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       draw,
  input  logic       erase,
  input  logic       draw_start,
  input  logic       draw_end,
  input  logic [7:0] block_x,
  input  logic [6:0] block_y,
  input  logic [7:0] block_w,
  input  logic [3:0] block_h,
  input  logic [2:0] block_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic [0:0] plot,
  output logic       done_draw,
  output logic       done_erase,
  output logic       done_screen
);

  draw_req_t  acc, req_q, cur;
  logic [1:0] state, nxt;
  cmd_e       nxt_cmd;
  logic       req_any, acc_zero, load, active, onscreen;
  logic [2:1] fin_pipe;   // last pixel -> output stage -> drained
  logic [8:0] cx;
  logic [7:0] cy;
  logic       clast;
  logic [2:0] pix_colour;

  // Request arbitration and the command image latched on acceptance.
  always_comb begin
    acc.cmd    = CMD_DRAW;
    acc.ox     = block_x;
    acc.oy     = block_y;
    acc.w      = block_w;
    acc.h      = {3'b000, block_h};
    acc.colour = block_colour;
    if (draw_start || draw_end) begin
      acc.cmd    = draw_start ? CMD_START : CMD_END;
      acc.ox     = '0;
      acc.oy     = '0;
      acc.w      = 8'(SCREEN_W);
      acc.h      = 7'(SCREEN_H);
      acc.colour = draw_start ? START_COLOUR : GAMEOVER_COLOUR;
    end else if (erase) begin
      acc.cmd    = CMD_ERASE;
      acc.colour = BG_COLOUR;
    end
  end

  assign req_any  = draw | erase | draw_start | draw_end;
  assign acc_zero = (acc.w == '0) || (acc.h == '0);
  assign load     = (state == S_IDLE) && req_any && !acc_zero;
  // The counter loads from the live arbitration result, then runs on the latched copy.
  assign cur      = (state == S_IDLE) ? acc : req_q;

  xy_scan_counter u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load),
    .step     (active),
    .origin_x (cur.ox),
    .origin_y (cur.oy),
    .w        (cur.w),
    .h        (cur.h),
    .x        (cx),
    .y        (cy),
    .last     (clast)
  );

  assign onscreen = (cx < 9'(SCREEN_W)) && (cy < 8'(SCREEN_H));

`ifdef BLOCK_BORDER_EN
  logic [8:0] end_x;
  logic [7:0] end_y;
  assign end_x = {1'b0, req_q.ox} + {1'b0, req_q.w} - 9'd1;
  assign end_y = {1'b0, req_q.oy} + {1'b0, req_q.h} - 8'd1;

  always_comb begin
    pix_colour = req_q.colour;
    if (req_q.cmd == CMD_DRAW &&
        (cx == {1'b0, req_q.ox} || cx == end_x || cy == {1'b0, req_q.oy} || cy == end_y))
      pix_colour = BORDER_COLOUR;
  end
`else
  assign pix_colour = req_q.colour;
`endif

  always_comb begin
    nxt     = state;
    nxt_cmd = req_q.cmd;
    case (state)
      S_IDLE: if (req_any) begin
        nxt     = acc_zero ? S_DONE : S_SCAN;
        nxt_cmd = acc.cmd;
      end
      // Wait for the final pixel to leave the output register plus one idle
      // cycle, so done trails acceptance by w*h+2 cycles.
      S_SCAN: if (fin_pipe[2]) nxt = S_DONE;
      S_DONE: nxt = S_HOLD;
      S_HOLD: if (!cmd_level(req_q.cmd, draw, erase, draw_start, draw_end)) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      req_q       <= '0;
      active      <= 1'b0;
      fin_pipe    <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      plot        <= '0;
      done_draw   <= 1'b0;
      done_erase  <= 1'b0;
      done_screen <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_any) req_q <= acc;
      if (load)                 active <= 1'b1;
      else if (active && clast) active <= 1'b0;
      fin_pipe <= {fin_pipe[1], active & clast};
      plot     <= active & onscreen;
      if (active) begin
        vga_x      <= cx[7:0];
        vga_y      <= cy[6:0];
        vga_colour <= pix_colour;
      end
      // Flags follow the next state so they line up with DONE/HOLD.
      done_draw   <= (nxt == S_DONE) && (nxt_cmd == CMD_DRAW);
      done_erase  <= (nxt == S_DONE) && (nxt_cmd == CMD_ERASE);
      done_screen <= (nxt == S_DONE || nxt == S_HOLD) && is_screen(nxt_cmd);
    end
  end

endmodule

// File: doc/block_draw_engine.md
BLOCK_DRAW_ENGINE -- requirements
Module: block_draw_engine

Interface
REQ-001 SHALL have port clk, input, 1 -- single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 -- reset, asynchronous and active-low.
REQ-003 SHALL have port draw, input, 1 -- level request: paint the block at the latched position in the block colour.
REQ-004 SHALL have port erase, input, 1 -- level request: paint the block area in the background colour 3'b000.
REQ-005 SHALL have port draw_start, input, 1 -- level request: fill the full 160x120 screen with START_COLOUR.
REQ-006 SHALL have port draw_end, input, 1 -- level request: fill the full screen with GAMEOVER_COLOUR.
REQ-007 SHALL have ports block_x [7:0], block_y [6:0], block_w [7:0], block_h [3:0], block_colour [2:0], all inputs -- block geometry and colour.
REQ-008 SHALL have outputs vga_x [7:0], vga_y [6:0], vga_colour [2:0], plot [0:0] -- pixel write port.
REQ-009 SHALL have outputs done_draw, done_erase and done_screen, each 1 bit -- completion indications.

Function
REQ-010 SHALL implement the states IDLE, SCAN, DONE and HOLD.
REQ-011 IDLE SHALL accept a request by priority draw_start > draw_end > erase > draw, and SHALL latch the geometry, colour and command type on the accepting edge.
REQ-012 SCAN SHALL emit one pixel per cycle in row-major order: x from origin to origin+w-1, then y increments.
- Full-screen commands SHALL use origin (0,0), w=160, h=120.
REQ-013 The first pixel SHALL appear on the cycle after acceptance; a command of w*h pixels SHALL complete in w*h+2 cycles from acceptance to the done pulse.
REQ-014 All outputs SHALL be registered.
- plot SHALL be 1 only in SCAN and only for pixels with x<160 and y<120.
- Off-screen pixels SHALL still consume a cycle.
REQ-015 Sums x+w and y+h SHALL be computed at 9 and 8 bits respectively, so that no wrap-around occurs.
REQ-016 A w=0 or h=0 request SHALL go directly to DONE, with no plot asserted.
REQ-017 DONE SHALL last exactly one cycle.
- For a draw command it SHALL pulse done_draw; for an erase command it SHALL pulse done_erase.
- For a full-screen command it SHALL assert done_screen, and done_screen SHALL stay high through HOLD.
REQ-018 HOLD SHALL wait until the latched request input is 0, then return to IDLE.
- Full-screen fills SHALL therefore run once per assertion of the request.
REQ-019 Deasserting a request mid-SCAN SHALL NOT abort the scan; the scan SHALL complete and the done indication SHALL still be issued.
REQ-020 Input changes during SCAN SHALL be ignored, because only the latched values are used.

Reset
REQ-021 When resetn is 0, the block SHALL enter IDLE and drive vga_x=0, vga_y=0, vga_colour=0, plot=0, done_draw=0, done_erase=0 and done_screen=0.
REQ-022 Reset during SCAN SHALL abort immediately, with no further plot and no done pulse.
REQ-023 After reset is released, the first acceptance SHALL occur no earlier than the first rising edge.

Configuration
REQ-024 The macro BLOCK_BORDER_EN SHALL control a border on block draws.
- When defined: a draw command SHALL colour perimeter pixels (first/last column, first/last row) with BORDER_COLOUR and interior pixels with block_colour.
- When undefined: all pixels SHALL use block_colour.
- Erase and full-screen fills SHALL be unaffected in both cases.

Structure
REQ-025 The shared package display_pkg SHALL hold SCREEN_W=160, SCREEN_H=120, START_COLOUR, GAMEOVER_COLOUR, BORDER_COLOUR, BG_COLOUR=3'b000 and the engine state encoding.
REQ-026 The x/y raster counter SHALL be a single sub-module, xy_scan_counter, with inputs origin, w, h and step, and outputs x, y and last.

Verification
REQ-027 Draw request with block_x=10, block_y=20, w=3, h=2, colour=3'b100: plots (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), and done_draw pulses on cycle 8 after acceptance.
REQ-028 erase and draw raised in the same cycle: only erase is executed, with colour 0 and a done_erase pulse; draw is accepted only after HOLD completes.
REQ-029 draw_start held high: exactly 19200 plots, then done_screen stays high with no refill until draw_start falls.
REQ-030 block_x=158, w=4, h=1: 2 plots (158,159) over 4 scan cycles, then done_draw.
REQ-031 resetn pulsed low at pixel 5 of a 20-pixel draw: plot falls asynchronously, no done_draw pulse, and a new draw request is accepted after reset.
REQ-032 With BLOCK_BORDER_EN defined, a 4x3 draw gives the pixel (1..2,1) block_colour and the 10 perimeter pixels BORDER_COLOUR.
